// File: rtl/if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buffer
// Description : Two-entry fetch-to-decode buffer. Holds {PC, PC+4, instr}
//               per fetched word, back-pressures the PC stage through
//               if_ready, and discards everything on a taken-branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_buffer #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [ADDR_W-1:0]  if_pc,
    input  logic [ADDR_W-1:0]  if_pc_plus4,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    output logic               id_valid,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_plus4,
    output logic [INSTR_W-1:0] id_instr,
    input  logic               id_ready,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    // Head entry drives decode; tail entry only fills while decode stalls.
    logic [ADDR_W-1:0]  r_head_pc;
    logic [ADDR_W-1:0]  r_head_pc4;
    logic [INSTR_W-1:0] r_head_instr;
    logic [ADDR_W-1:0]  r_tail_pc;
    logic [ADDR_W-1:0]  r_tail_pc4;
    logic [INSTR_W-1:0] r_tail_instr;
    logic [1:0]         r_occ;

    logic w_push;
    logic w_pop;

    // Handshake flags decode only the occupancy register, so no input
    // reaches an output combinationally.
    assign id_valid  = (r_occ != c_OCC_EMPTY);
    assign if_ready  = (r_occ != c_OCC_FULL);
    assign w_push    = if_valid & if_ready;
    assign w_pop     = id_valid & id_ready;

    assign id_pc       = r_head_pc;
    assign id_pc_plus4 = r_head_pc4;
    assign id_instr    = r_head_instr;
    assign occupancy   = r_occ;

    // Occupancy and entry update; flush wins, empty entries are kept at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ        <= c_OCC_EMPTY;
            r_head_pc    <= '0;
            r_head_pc4   <= '0;
            r_head_instr <= '0;
            r_tail_pc    <= '0;
            r_tail_pc4   <= '0;
            r_tail_instr <= '0;
        end else if (flush) begin
            r_occ        <= c_OCC_EMPTY;
            r_head_pc    <= '0;
            r_head_pc4   <= '0;
            r_head_instr <= '0;
            r_tail_pc    <= '0;
            r_tail_pc4   <= '0;
            r_tail_instr <= '0;
        end else begin
            case (r_occ)
                c_OCC_EMPTY: begin
                    if (w_push) begin
                        r_head_pc    <= if_pc;
                        r_head_pc4   <= if_pc_plus4;
                        r_head_instr <= if_instr;
                        r_occ        <= c_OCC_ONE;
                    end
                end
                c_OCC_ONE: begin
                    if (w_push && w_pop) begin
                        // Full-throughput case: replace head, tail untouched.
                        r_head_pc    <= if_pc;
                        r_head_pc4   <= if_pc_plus4;
                        r_head_instr <= if_instr;
                    end else if (w_push) begin
                        r_tail_pc    <= if_pc;
                        r_tail_pc4   <= if_pc_plus4;
                        r_tail_instr <= if_instr;
                        r_occ        <= c_OCC_FULL;
                    end else if (w_pop) begin
                        r_head_pc    <= '0;
                        r_head_pc4   <= '0;
                        r_head_instr <= '0;
                        r_occ        <= c_OCC_EMPTY;
                    end
                end
                c_OCC_FULL: begin
                    // if_ready is low here, so only a pop can happen.
                    if (w_pop) begin
                        r_head_pc    <= r_tail_pc;
                        r_head_pc4   <= r_tail_pc4;
                        r_head_instr <= r_tail_instr;
                        r_tail_pc    <= '0;
                        r_tail_pc4   <= '0;
                        r_tail_instr <= '0;
                        r_occ        <= c_OCC_ONE;
                    end
                end
                default: begin
                    r_occ <= c_OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid_buffer
// Description : Scoreboard bench for if_id_skid_buffer. Accepted words are
//               queued, and the head of the queue is compared with id_*.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_buffer;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               rst;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pc_plus4;
    logic [INSTR_W-1:0] if_instr;
    logic               if_ready;
    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [ADDR_W-1:0]  id_pc_plus4;
    logic [INSTR_W-1:0] id_instr;
    logic               id_ready;
    logic               flush;
    logic [1:0]         occupancy;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } word_t;

    word_t q[$];
    int    n_total = 0;
    int    n_bad   = 0;

    if_id_skid_buffer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_pc_plus4(if_pc_plus4),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4),
        .id_instr   (id_instr),
        .id_ready   (id_ready),
        .flush      (flush),
        .occupancy  (occupancy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare visible state against the scoreboard queue.
    task automatic check_state(input string tag);
        check({tag, ".occ"}, 64'(occupancy), 64'(q.size()));
        check({tag, ".id_valid"}, 64'(id_valid), 64'(q.size() != 0));
        check({tag, ".if_ready"}, 64'(if_ready), 64'(q.size() != 2));
        if (q.size() != 0) begin
            check({tag, ".id_pc"}, id_pc, q[0].pc);
            check({tag, ".id_pc4"}, id_pc_plus4, q[0].pc4);
            check({tag, ".id_instr"}, 64'(id_instr), 64'(q[0].instr));
        end else begin
            check({tag, ".id_pc_zero"}, id_pc, 64'd0);
            check({tag, ".id_pc4_zero"}, id_pc_plus4, 64'd0);
            check({tag, ".id_instr_zero"}, 64'(id_instr), 64'd0);
        end
    endtask

    // Drive one cycle of stimulus (called 1 ns after a rising edge), update
    // the scoreboard at the edge, then check 1 ns later.
    task automatic step(input string tag, input logic v, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        word_t w;
        bit    do_push;
        bit    do_pop;
        if_valid    = v;
        if_pc       = pc;
        if_pc_plus4 = pc + 64'd4;
        if_instr    = $urandom;
        id_ready    = rdy;
        flush       = fl;
        w.pc    = if_pc;
        w.pc4   = if_pc_plus4;
        w.instr = if_instr;
        do_push = v && (q.size() < 2);
        do_pop  = rdy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(w);
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        rst         = 1'b1;
        if_valid    = 1'b0;
        if_pc       = '0;
        if_pc_plus4 = '0;
        if_instr    = '0;
        id_ready    = 1'b0;
        flush       = 1'b0;
        #12;
        check_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming: one word per cycle with decode always ready.
        for (int i = 0; i < 40; i++) begin
            step("stream", 1'b1, 64'(i * 4), 1'b1, 1'b0);
        end
        step("stream_drain", 1'b0, 64'd0, 1'b1, 1'b0);

        // Stall fill, then a held word that must not be accepted.
        step("fill0", 1'b1, 64'h100, 1'b0, 1'b0);
        step("fill1", 1'b1, 64'h104, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("held", 1'b1, 64'h108, 1'b0, 1'b0);
        end
        // Release: 0x100 leaves, then 0x108 enters as 0x104 leaves, no gap.
        step("rel0", 1'b1, 64'h108, 1'b1, 1'b0);
        step("rel1", 1'b1, 64'h108, 1'b1, 1'b0);
        step("rel2", 1'b0, 64'h0, 1'b1, 1'b0);
        step("rel3", 1'b0, 64'h0, 1'b1, 1'b0);

        // Flush with a full buffer and a word on the input.
        step("pre_fl0", 1'b1, 64'h200, 1'b0, 1'b0);
        step("pre_fl1", 1'b1, 64'h204, 1'b0, 1'b0);
        step("flush", 1'b1, 64'h208, 1'b0, 1'b1);
        check("flush.tail_pc", dut.r_tail_pc, 64'd0);
        step("target", 1'b1, 64'h300, 1'b0, 1'b0);
        step("target_drain", 1'b0, 64'h0, 1'b1, 1'b0);

        // Simultaneous push and pop at occupancy 1 leaves the tail alone.
        step("sp_head", 1'b1, 64'h10, 1'b0, 1'b0);
        step("sp_both", 1'b1, 64'h14, 1'b1, 1'b0);
        check("sp.tail_pc", dut.r_tail_pc, 64'd0);
        // Drain to empty: all id_* fields return to zero.
        step("drain", 1'b0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with a full buffer.
        step("pre_rst0", 1'b1, 64'h400, 1'b0, 1'b0);
        step("pre_rst1", 1'b1, 64'h404, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check_state("async_rst");
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 64'h500, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Two-entry fetch-to-decode buffer between the program counter/instruction memory (IF) and the decode stage (ID).
- Captures {PC, PC+4, instruction} per fetched word with a valid/ready handshake.
- Back-pressures the PC register through if_ready, so a decode stall never drops or duplicates a fetch.
- Provides a single-cycle flush for taken branches.

Parameters:
ADDR_W, 64, width of PC and PC+4 fields
INSTR_W, 32, instruction word width

Ports:
clk  input  1  pipeline clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
if_valid  input  1  fetch word present on if_* this cycle
if_pc  input  ADDR_W  PC of fetched instruction (currPC from PC stage)
if_pc_plus4  input  ADDR_W  PC+4 of fetched instruction (for BL link value)
if_instr  input  INSTR_W  instruction from instruction memory
if_ready  output  1  buffer can accept a word; PC stage holds PC when low
id_valid  output  1  head entry valid toward decode
id_pc  output  ADDR_W  head entry PC
id_pc_plus4  output  ADDR_W  head entry PC+4
id_instr  output  INSTR_W  head entry instruction
id_ready  input  1  decode consumes head this cycle
flush  input  1  discard all buffered and incoming words (taken branch, PCSrc=1)
occupancy  output  2  entries held, 0..2

Behaviour:
- Storage: head entry (drives id_*) and tail entry. Occupancy counter 0..2. All outputs registered; no combinational path from any input to any output.
- Reset (async, rst=1): occupancy=0, head and tail fields all 0, id_valid=0, if_ready=1. Takes effect immediately, mid-operation included; buffered words are lost.
- Derived signals:
  - id_valid = (occupancy != 0).
  - if_ready = (occupancy != 2); depends only on state, never on id_ready.
  - push = if_valid & if_ready.
  - pop = id_valid & id_ready.
- Per-edge update, priority order:
  1. flush=1: occupancy<=0, head and tail fields <=0; simultaneous push is dropped; pop is irrelevant.
  2. occ=0, push: head<=in, occ<=1.
  3. occ=1, push & pop: head<=in, occ stays 1. Full throughput, one word per cycle.
  4. occ=1, push only: tail<=in, occ<=2.
  5. occ=1, pop only: head<=0, occ<=0.
  6. occ=2, pop: head<=tail, tail<=0, occ<=1. No push is possible (if_ready=0).
  7. Otherwise: hold.
- if_valid while if_ready=0 is ignored. Upstream must hold the word; a PC stage enable driven by if_ready guarantees this.
- id_ready while id_valid=0 has no effect.
- Latency: a word pushed at edge N appears on id_* after edge N when occ was 0, or occ was 1 with a pop in the same cycle.
- Ordering: strictly FIFO; words leave in the order accepted.
- Invalid entries read as all-zero, so id_instr=0 whenever id_valid=0 (deterministic bubble).
- Width rule: fields are stored verbatim. No arithmetic; PC+4 is not recomputed here.
- flush deasserted while if_valid=1 on the next cycle: the new word (branch target) is accepted normally at that edge.

Test Plan:
- Reset: assert rst mid-run with occ=2 -> immediately occ=0, id_valid=0, id_pc=0, if_ready=1, without waiting for a clock edge.
- Streaming: id_ready=1, push PC=0,4,8,... for 40 cycles -> id_pc lags if_pc by exactly 1 cycle, id_pc_plus4=id_pc+4, occ stays 1, if_ready stays 1.
- Stall fill: push PC=0x100, 0x104 with id_ready=0 -> occ=2, if_ready=0. Present PC=0x108 held for 3 cycles -> not accepted. Then id_ready=1 -> outputs 0x100, 0x104, 0x108 in order with no gap after the first pop.
- Flush: occ=2 (0x200, 0x204), flush=1 with if_valid=1 PC=0x208 -> next cycle occ=0, id_valid=0, id_instr=0. Next cycle push PC=300 -> id_pc=300 after one edge.
- Simultaneous push/pop at occ=1 (head 0x10, push 0x14, id_ready=1) -> after edge head=0x14, occ=1, tail untouched (0).
- Drain to empty: occ=1, pop without push -> id_valid=0 and all id_* fields zero after the edge.
